// File: rtl/mac8_feeder.sv
// mac8_feeder: sequences A/B operands into an N-lane skewed MAC array and captures C = A*B
module mac8_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N = 8,
  localparam int AW = $clog2(N),
  localparam int TW = $clog2(2 * N),
  localparam int CW = 3 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_wr_en,
  input  logic [AW-1:0]         a_wr_row,
  input  logic [AW-1:0]         a_wr_col,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  b_wr_en,
  input  logic [AW-1:0]         b_wr_idx,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  En_in,
  output logic                  Clr_in,
  output logic [DATA_WIDTH-1:0] b_in,
  output logic [DATA_WIDTH-1:0] a_in [0:N-1],
  input  logic [CW-1:0]         c_in [0:N-1],
  output logic [CW-1:0]         c_res [0:N-1]
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;
  state_t state, nxt;
  logic [TW-1:0] t;
  logic [DATA_WIDTH-1:0] a_mem [0:N-1][0:N-1];
  logic [DATA_WIDTH-1:0] b_mem [0:N-1];
  // one CLEAR cycle, 2N RUN cycles, one CAPTURE cycle, then back to IDLE
  always_comb begin
    nxt = state == IDLE ? (start ? CLEAR : IDLE) :
          state == CLEAR ? RUN :
          state == RUN ? (t == TW'(2 * N - 1) ? CAPTURE : RUN) : IDLE;
  end
  // stage-0 array controls and the B stream for the first N run cycles
  always_comb begin
    busy = state != IDLE;
    Clr_in = state == CLEAR;
    En_in = state == RUN && t < TW'(N);
    b_in = En_in ? b_mem[t[AW-1:0]] : '0;
  end
  // lane g needs A[g][k] exactly when B[k] reaches it, g+1 cycles after issue
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [TW:0] d;
    assign d = {1'b0, t} - (TW + 1)'(g + 1);
    assign a_in[g] = state == RUN && d < (TW + 1)'(N) ? a_mem[g][d[AW-1:0]] : '0;
  end
  // state, run counter, done pulse, host-written operands and captured results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      done <= 1'b0;
      for (int i = 0; i < N; i++) begin
        b_mem[i] <= '0;
        c_res[i] <= '0;
        for (int j = 0; j < N; j++) a_mem[i][j] <= '0;
      end
    end else begin
      state <= nxt;
      t <= state == RUN ? t + 1'b1 : '0;
      done <= state == CAPTURE;
      if (state == IDLE && a_wr_en) a_mem[a_wr_row][a_wr_col] <= a_wr_data;
      if (state == IDLE && b_wr_en) b_mem[b_wr_idx] <= b_wr_data;
      if (state == CAPTURE) c_res <= c_in;
    end
  end
endmodule

// File: doc/mac8_feeder.md
# mac8_feeder

Sequencer that drives the 8-lane MAC array: holds an N×N A matrix and an N-element B vector written by the host, then on `start` issues the clear pulse, the B stream and the per-lane skewed A operands. It collects the N results as C = A·B. It sits between the host/FIFO side and the MAC array, aligning each lane's A operand with that lane's delayed B and En/Clr.

## Interface
- `DATA_WIDTH`, 8, operand width; results are 3*DATA_WIDTH bits, unsigned.
- `N`, 8, lane count, matrix dimension and B length.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a_wr_en`  in  1  write A[a_wr_row][a_wr_col].
- `a_wr_row`, `a_wr_col`  in  $clog2(N)  A write address.
- `a_wr_data`  in  DATA_WIDTH  A write data.
- `b_wr_en`  in  1  write B[b_wr_idx].
- `b_wr_idx`  in  $clog2(N)  B write address.
- `b_wr_data`  in  DATA_WIDTH  B write data.
- `start`  in  1  begin a run; sampled only in IDLE.
- `busy`  out  1  high from the CLEAR state through the CAPTURE state.
- `done`  out  1  single-cycle pulse when `c_res` is updated.
- `En_in`, `Clr_in`  out  1  array stage-0 enable and clear.
- `b_in`  out  DATA_WIDTH  array B stream.
- `a_in[0:N-1]`  out  DATA_WIDTH each  per-lane A operand.
- `c_in[0:N-1]`  in  3*DATA_WIDTH each  array accumulator outputs.
- `c_res[0:N-1]`  out  3*DATA_WIDTH each  captured results, held until the next capture.

## Operation
- Array contract:
  - `b_in`, `En_in` and `Clr_in` pass through one register per stage. Lane i sees them i+1 cycles later.
  - Lane i accumulates `a_in[i]`·b at the clock edge when its En is high.
  - Lane i's accumulator clears at the clock edge when its Clr is high.
  - `c_in[i]` is the registered accumulator value.
- States: IDLE → CLEAR → RUN → CAPTURE → IDLE.
- IDLE:
  - All array drives are 0.
  - `start`=1 moves the FSM to CLEAR.
- CLEAR (1 cycle): `Clr_in`=1, `En_in`=0, `b_in`=0.
- RUN (2N cycles): a counter t runs 0..2N-1.
  - For t<N: `En_in`=1 and `b_in`=B[t].
  - For t≥N: `En_in`=0 and `b_in`=0.
  - `a_in[i]` = A[i][t-1-i] when 0 ≤ t-1-i ≤ N-1; otherwise 0.
  - Transition to CAPTURE after t=2N-1.
- CAPTURE (1 cycle): `c_res[i]` ← `c_in[i]` for every lane. Next state is IDLE.
- `done` is registered: high in the first IDLE cycle after CAPTURE.
- Writes:
  - Accepted in IDLE only; ignored while `busy`=1.
  - A write and a B write in the same cycle are both performed.
- `start` while `busy`=1 is ignored. It is not queued.
- A `start` in the same cycle as `done` is accepted.
- Width: 3*DATA_WIDTH holds N·(2^DATA_WIDTH−1)² for N ≤ 256. No saturation logic.
- Reset (at any time, including mid-run):
  - FSM returns to IDLE; t=0.
  - A, B and `c_res` are cleared to 0.
  - `busy`, `done`, `En_in`, `Clr_in`, `b_in` and all `a_in` are 0.
  - The array is reset by the same event; no partial result is captured.

## Timing
- Cycle 0: `start` is sampled in IDLE.
- Cycle 1: CLEAR.
  - `busy`=1, `Clr_in`=1.
  - Lane i clears at the end of cycle 1+i+1, before its first accumulate.
- Cycles 2..2N+1: RUN with t = cycle−2.
  - Lane i accumulates A[i][k]·B[k] at the end of cycle 2+k+i+1.
  - The last accumulate (lane N-1, k=N-1) is at the end of cycle 2N+1.
- Cycle 2N+2: CAPTURE. For N=8 this is cycle 18.
- Cycle 2N+3:
  - `done`=1 and `busy`=0; `c_res` is valid.
  - For N=8 this is cycle 19.
- Start-to-done latency is 2N+3 cycles.
- Back-to-back minimum issue interval is 2N+3 cycles.

## Test plan
- Identity and counting vector:
  - Stimulus: A=I, B=[1..8], `start` at cycle 0.
  - Required response: `Clr_in`=1 only at cycle 1; `done` only at cycle 19; `c_res`=[1,2,…,8].
- Full-scale overflow check:
  - Stimulus: all A and B = 255.
  - Required response: every `c_res[i]`=520200 (0x07F008); no wrap.
- Skew check:
  - Stimulus: A[i][j]=8i+j+1, B=[1,0,0,0,0,0,0,0].
  - Required response: `a_in[3]`=25 at cycle 2+0+3+1=6; `c_res[i]`=8i+1.
- Back-to-back runs:
  - Stimulus: run 1 with B=all 1 and A=all 2, then `start` held high through the `done` cycle. Between the two runs, write B=all 0 while `busy`=0.
  - Required response: run 1 gives `c_res`=16 in every lane; the second run's `c_res` reflects only the new data (no carry-over, confirming the clear).
- Ignored requests while busy:
  - Stimulus: `start` pulses and A/B writes at cycles 5–10 of a run.
  - Required response: results are unchanged; `done` fires once; a readback run shows the memory unmodified.
- Reset mid-run:
  - Stimulus: `rst` asserted at cycle 9 of a run.
  - Required response: all outputs read 0 asynchronously, no `done`. A fresh load and run after release gives the correct result.
